// File: rtl/regfile_debug_port.sv
// rtl/regfile_debug_port.sv - debug read/write access to the core register file
//
// Purpose:
//   Takes one debug register command at a time. It halts the core, waits for
//   the core to report that it is stalled, and then performs a single-cycle
//   access on the register file ports. Outside that access cycle, the core
//   writeback and rs1 read ports pass straight through to the register file.
//   If the core does not halt within TIMEOUT cycles, the block returns an
//   error response and performs no access.
//
// Ports:
//   clk, reset                        clock (rising edge), async active-high reset
//   io_cmd_valid/ready/write/addr/wdata   debug command handshake and payload
//   io_rsp_valid/ready/rdata/err          debug response handshake and payload
//   io_halt_req, io_halted                core stall request / acknowledge
//   io_core_rd_addr/wen/data, io_core_rs1_addr   core side of the register file
//   io_rf_rd_addr/wen/data, io_rf_rs1_addr       register file write/read address
//   io_rf_rs1_data                              register file combinational read data

module regfile_debug_port #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_cmd_valid,
   output logic        io_cmd_ready,
   input  logic        io_cmd_write,
   input  logic [4:0]  io_cmd_addr,
   input  logic [31:0] io_cmd_wdata,
   output logic        io_rsp_valid,
   input  logic        io_rsp_ready,
   output logic [31:0] io_rsp_rdata,
   output logic        io_rsp_err,
   output logic        io_halt_req,
   input  logic        io_halted,
   input  logic [4:0]  io_core_rd_addr,
   input  logic        io_core_rd_wen,
   input  logic [31:0] io_core_rd_data,
   input  logic [4:0]  io_core_rs1_addr,
   output logic [4:0]  io_rf_rd_addr,
   output logic        io_rf_rd_wen,
   output logic [31:0] io_rf_rd_data,
   output logic [4:0]  io_rf_rs1_addr,
   input  logic [31:0] io_rf_rs1_data
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HALT_WAIT = 2'd1,
      ACCESS    = 2'd2,
      RESP      = 2'd3
   } state_t;

   // The counter holds the number of HALT_WAIT cycles already spent without
   // a halt. The cycle in which it equals TIMEOUT-1 is the last one allowed.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [7:0]  wait_cnt, wait_cnt_nxt;
   logic        accept;
   logic        timeout_hit;

   logic        cap_write;
   logic [4:0]  cap_addr;
   logic [31:0] cap_wdata;
   logic [31:0] rdata_q;
   logic        err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      accept       = 1'b0;
      timeout_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (io_cmd_valid) begin
               accept       = 1'b1;
               state_nxt    = HALT_WAIT;
               wait_cnt_nxt = 8'd0;
            end
         end
         HALT_WAIT: begin
            if (io_halted) begin
               state_nxt    = ACCESS;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_hit  = 1'b1;
               state_nxt    = RESP;
               wait_cnt_nxt = 8'd0;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         ACCESS: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (io_rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt    = IDLE;
            wait_cnt_nxt = 8'd0;
         end
      endcase
   end

   // Captured command and response payload
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_write <= 1'b0;
         cap_addr  <= 5'd0;
         cap_wdata <= 32'd0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            cap_write <= io_cmd_write;
            cap_addr  <= io_cmd_addr;
            cap_wdata <= io_cmd_wdata;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
         end
         if (timeout_hit) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
         end
         if (state == ACCESS) begin
            err_q <= 1'b0;
            // Register x0 reads as zero whatever the register file returns.
            // Writes always return zero.
            if (!cap_write && (cap_addr != 5'd0)) begin
               rdata_q <= io_rf_rs1_data;
            end else begin
               rdata_q <= 32'd0;
            end
         end
      end
   end

   // While reset is asserted, ready is gated so the released IDLE state is not
   // advertised before the first clean cycle.
   assign io_cmd_ready = (state == IDLE) && !reset;
   assign io_halt_req  = (state != IDLE);
   assign io_rsp_valid = (state == RESP);
   assign io_rsp_rdata = rdata_q;
   assign io_rsp_err   = err_q;

   // The debug block owns the register file ports only during ACCESS. A core
   // writeback in that cycle is dropped. The core is halted then, so none is
   // expected.
   always_comb begin
      io_rf_rd_addr  = io_core_rd_addr;
      io_rf_rd_wen   = io_core_rd_wen;
      io_rf_rd_data  = io_core_rd_data;
      io_rf_rs1_addr = io_core_rs1_addr;
      if (state == ACCESS) begin
         io_rf_rd_addr  = cap_addr;
         io_rf_rd_wen   = cap_write && (cap_addr != 5'd0);
         io_rf_rd_data  = cap_wdata;
         io_rf_rs1_addr = cap_addr;
      end
   end

endmodule

// File: tb/tb_regfile_debug_port.sv
// tb/tb_regfile_debug_port.sv - directed self-checking bench for regfile_debug_port

module tb_regfile_debug_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        halt_req;
   logic        halted;
   logic [4:0]  core_rd_addr;
   logic        core_rd_wen;
   logic [31:0] core_rd_data;
   logic [4:0]  core_rs1_addr;
   logic [4:0]  rf_rd_addr;
   logic        rf_rd_wen;
   logic [31:0] rf_rd_data;
   logic [4:0]  rf_rs1_addr;
   logic [31:0] rf_rs1_data;

   int total = 0;
   int bad   = 0;

   regfile_debug_port #(.TIMEOUT(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .io_cmd_valid     (cmd_valid),
      .io_cmd_ready     (cmd_ready),
      .io_cmd_write     (cmd_write),
      .io_cmd_addr      (cmd_addr),
      .io_cmd_wdata     (cmd_wdata),
      .io_rsp_valid     (rsp_valid),
      .io_rsp_ready     (rsp_ready),
      .io_rsp_rdata     (rsp_rdata),
      .io_rsp_err       (rsp_err),
      .io_halt_req      (halt_req),
      .io_halted        (halted),
      .io_core_rd_addr  (core_rd_addr),
      .io_core_rd_wen   (core_rd_wen),
      .io_core_rd_data  (core_rd_data),
      .io_core_rs1_addr (core_rs1_addr),
      .io_rf_rd_addr    (rf_rd_addr),
      .io_rf_rd_wen     (rf_rd_wen),
      .io_rf_rd_data    (rf_rd_data),
      .io_rf_rs1_addr   (rf_rs1_addr),
      .io_rf_rs1_data   (rf_rs1_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while the DUT is IDLE. Returns at the negedge of the
   // first HALT_WAIT cycle.
   task automatic send(input logic w, input logic [4:0] a, input logic [31:0] d, input string tag);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      #1;
      chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      chk({tag, "_hw_halt_req"}, 32'(halt_req), 32'd1);
      chk({tag, "_hw_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_hw_rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   // Called at a RESP negedge. Consumes the response and checks the return to IDLE.
   task automatic consume(input string tag);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk({tag, "_idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_idle_halt_req"}, 32'(halt_req), 32'd0);
      chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      reset         = 1'b1;
      cmd_valid     = 1'b0;
      cmd_write     = 1'b0;
      cmd_addr      = 5'd0;
      cmd_wdata     = 32'd0;
      rsp_ready     = 1'b0;
      halted        = 1'b1;
      core_rd_addr  = 5'd0;
      core_rd_wen   = 1'b0;
      core_rd_data  = 32'd0;
      core_rs1_addr = 5'd0;
      rf_rs1_data   = 32'h12345678;

      // Reset state
      #1;
      chk("rst_halt_req", 32'(halt_req), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", 32'(cmd_ready), 32'd1);

      // Pass-through in IDLE
      core_rd_addr  = 5'd7;
      core_rd_wen   = 1'b1;
      core_rd_data  = 32'h00000001;
      core_rs1_addr = 5'd9;
      #1;
      chk("pt_rd_addr", 32'(rf_rd_addr), 32'd7);
      chk("pt_rd_wen", 32'(rf_rd_wen), 32'd1);
      chk("pt_rd_data", rf_rd_data, 32'h00000001);
      chk("pt_rs1_addr", 32'(rf_rs1_addr), 32'd9);
      core_rd_wen = 1'b0;

      // Write x5 = 0xDEADBEEF with the core already halted
      @(negedge clk);
      send(1'b1, 5'd5, 32'hDEADBEEF, "w5");
      @(negedge clk);
      #1;
      chk("w5_acc_wen", 32'(rf_rd_wen), 32'd1);
      chk("w5_acc_addr", 32'(rf_rd_addr), 32'd5);
      chk("w5_acc_data", rf_rd_data, 32'hDEADBEEF);
      chk("w5_acc_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("w5_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("w5_rsp_err", 32'(rsp_err), 32'd0);
      chk("w5_rsp_rdata", rsp_rdata, 32'd0);
      chk("w5_rsp_wen_released", 32'(rf_rd_wen), 32'd0);
      consume("w5");

      // Read x0 returns zero even though the register file returns data
      @(negedge clk);
      send(1'b0, 5'd0, 32'd0, "r0");
      @(negedge clk);
      #1;
      chk("r0_acc_rs1_addr", 32'(rf_rs1_addr), 32'd0);
      chk("r0_acc_wen", 32'(rf_rd_wen), 32'd0);
      @(negedge clk);
      #1;
      chk("r0_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("r0_rsp_rdata", rsp_rdata, 32'd0);
      consume("r0");

      // Write x0 is suppressed
      @(negedge clk);
      send(1'b1, 5'd0, 32'hFFFFFFFF, "w0");
      @(negedge clk);
      #1;
      chk("w0_acc_wen", 32'(rf_rd_wen), 32'd0);
      @(negedge clk);
      #1;
      chk("w0_rsp_err", 32'(rsp_err), 32'd0);
      consume("w0");

      // Debug write x3 while the core also writes x7: only debug reaches the file
      @(negedge clk);
      core_rd_addr = 5'd7;
      core_rd_wen  = 1'b1;
      core_rd_data = 32'h00000001;
      send(1'b1, 5'd3, 32'hAAAA5555, "w3");
      chk("w3_hw_pt_addr", 32'(rf_rd_addr), 32'd7);
      @(negedge clk);
      #1;
      chk("w3_acc_addr", 32'(rf_rd_addr), 32'd3);
      chk("w3_acc_data", rf_rd_data, 32'hAAAA5555);
      chk("w3_acc_wen", 32'(rf_rd_wen), 32'd1);
      @(negedge clk);
      #1;
      chk("w3_rsp_pt_addr", 32'(rf_rd_addr), 32'd7);
      chk("w3_rsp_pt_data", rf_rd_data, 32'h00000001);
      core_rd_wen = 1'b0;
      consume("w3");

      // Read x5 with a stalled response; halted drops after ACCESS
      @(negedge clk);
      send(1'b0, 5'd5, 32'd0, "r5");
      @(negedge clk);
      #1;
      chk("r5_acc_rs1_addr", 32'(rf_rs1_addr), 32'd5);
      chk("r5_acc_wen", 32'(rf_rd_wen), 32'd0);
      @(negedge clk);
      #1;
      chk("r5_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("r5_rsp_rdata", rsp_rdata, 32'h12345678);
      chk("r5_rsp_err", 32'(rsp_err), 32'd0);
      halted    = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 5'd9;
      cmd_wdata = 32'h55555555;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
         chk($sformatf("stall%0d_rdata", i), rsp_rdata, 32'h12345678);
         chk($sformatf("stall%0d_halt_req", i), 32'(halt_req), 32'd1);
         chk($sformatf("stall%0d_ready", i), 32'(cmd_ready), 32'd0);
      end
      cmd_valid = 1'b0;
      consume("r5");
      @(negedge clk);
      #1;
      chk("r5_no_late_accept", 32'(halt_req), 32'd0);

      // Halt timeout with TIMEOUT=4
      send(1'b1, 5'd6, 32'h0BADF00D, "to");
      chk("to_hw0_wen", 32'(rf_rd_wen), 32'd0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("to_hw%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("to_hw%0d_halt_req", i), 32'(halt_req), 32'd1);
         chk($sformatf("to_hw%0d_wen", i), 32'(rf_rd_wen), 32'd0);
      end
      @(negedge clk);
      #1;
      chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("to_rsp_err", 32'(rsp_err), 32'd1);
      chk("to_rsp_rdata", rsp_rdata, 32'd0);
      chk("to_rsp_wen", 32'(rf_rd_wen), 32'd0);
      consume("to");

      // Reset during HALT_WAIT discards the command
      @(negedge clk);
      send(1'b1, 5'd4, 32'h44444444, "rh");
      reset = 1'b1;
      #1;
      chk("rh_halt_req", 32'(halt_req), 32'd0);
      chk("rh_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rh_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      reset  = 1'b0;
      halted = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rh_after%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
         chk($sformatf("rh_after%0d_wen", i), 32'(rf_rd_wen), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
